// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell is reused for WIDTH
// cycles, LSB first, with a start/busy/done handshake to the requester.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_opa, r_opb, r_sum, w_sum_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_cout, r_ovf;
  logic             w_fa_s, w_fa_c, w_load, w_step, w_last;

  full_adder u_fa (
    .i_a   (r_opa[0]),
    .i_b   (r_opb[0]),
    .i_cin (r_carry),
    .o_sum (w_fa_s),
    .o_cout(w_fa_c)
  );

  assign w_last = (r_cnt == LAST);

  // New result bit enters at the MSB; after WIDTH steps bit 0 sits at the LSB.
  always_comb begin
    w_sum_shift            = r_sum >> 1;
    w_sum_shift[WIDTH-1]   = w_fa_s;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_opa   <= a;
        r_opb   <= op_sub ? ~b : b;
        r_carry <= op_sub ? 1'b1 : cin;
        r_cnt   <= '0;
        r_sum   <= '0;
      end else if (w_step) begin
        r_sum   <= w_sum_shift;
        r_carry <= w_fa_c;
        r_opa   <= r_opa >> 1;
        r_opb   <= r_opb >> 1;
        if (w_last) begin
          // r_carry here is the carry into the MSB.
          r_cout <= w_fa_c;
          r_ovf  <= r_carry ^ w_fa_c;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: an 8-bit and a 1-bit instance on a
// shared clock and reset, checked against hand-computed results.

module tb_serial_add_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       s8_start, s8_op, s8_cin, s8_busy, s8_done, s8_cout, s8_ovf;
  logic [7:0] s8_a, s8_b, s8_sum;
  logic       s1_start, s1_op, s1_cin, s1_busy, s1_done, s1_cout, s1_ovf;
  logic [0:0] s1_a, s1_b, s1_sum;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .op_sub(s8_op),
    .a(s8_a), .b(s8_b), .cin(s8_cin), .busy(s8_busy), .done(s8_done),
    .sum(s8_sum), .cout(s8_cout), .overflow(s8_ovf)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .op_sub(s1_op),
    .a(s1_a), .b(s1_b), .cin(s1_cin), .busy(s1_busy), .done(s1_done),
    .sum(s1_sum), .cout(s1_cout), .overflow(s1_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One 8-bit operation; optionally re-pulses start (with other operands) at edges T+3 and T+8.
  task automatic op8(input string tag, input logic sub, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic [7:0] esum, input logic ec, input logic eo,
                     input bit inject);
    int lat   = -1;
    int dones = 0;
    int early = 0;
    @(negedge clk);
    s8_op = sub; s8_a = a; s8_b = b; s8_cin = c; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (s8_done) begin
        dones++;
        if (lat < 0) lat = n;
      end
      if (n < 8 && !s8_busy) early++;
      if (inject && (n == 2 || n == 7)) begin
        s8_start = 1'b1; s8_a = ~a; s8_b = 8'h55; s8_op = ~sub; s8_cin = ~c;
      end else begin
        s8_start = 1'b0;
      end
    end
    chk({tag, " latency"}, lat, 8);
    chk({tag, " done_pulses"}, dones, 1);
    chk({tag, " busy_drop"}, early, 0);
    chk({tag, " sum"}, s8_sum, esum);
    chk({tag, " cout"}, s8_cout, ec);
    chk({tag, " ovf"}, s8_ovf, eo);
  endtask

  initial begin
    int dones;
    logic [1:0] tot;
    rst_n = 1'b0;
    s8_start = 0; s8_op = 0; s8_cin = 0; s8_a = 0; s8_b = 0;
    s1_start = 0; s1_op = 0; s1_cin = 0; s1_a = 0; s1_b = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", s8_busy, 0);
    chk("rst done", s8_done, 0);
    chk("rst sum", s8_sum, 0);
    chk("rst cout", s8_cout, 0);
    chk("rst ovf", s8_ovf, 0);
    chk("rst1 busy", s1_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    op8("add5A3C", 0, 8'h5A, 8'h3C, 0, 8'h96, 0, 1, 0);
    op8("addFF01", 0, 8'hFF, 8'h01, 0, 8'h00, 1, 0, 0);
    op8("add7F00c", 0, 8'h7F, 8'h00, 1, 8'h80, 0, 1, 0);
    op8("sub1020", 1, 8'h10, 8'h20, 0, 8'hF0, 0, 0, 0);
    op8("sub2010", 1, 8'h20, 8'h10, 0, 8'h10, 1, 0, 0);
    op8("sub8001c", 1, 8'h80, 8'h01, 0, 8'h7F, 1, 1, 0);
    op8("ignore", 0, 8'h12, 8'h34, 0, 8'h46, 0, 0, 1);
    op8("sub8001", 1, 8'h80, 8'h01, 1, 8'h7F, 1, 1, 0);

    // Reset mid-run once the counter has reached 4.
    @(negedge clk);
    s8_op = 0; s8_a = 8'h5A; s8_b = 8'h3C; s8_cin = 0; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst busy", s8_busy, 0);
    chk("midrst done", s8_done, 0);
    chk("midrst sum", s8_sum, 0);
    chk("midrst cout", s8_cout, 0);
    chk("midrst ovf", s8_ovf, 0);
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (s8_done || s8_busy) dones++;
    end
    chk("midrst quiet", dones, 0);
    op8("postrst", 0, 8'hC3, 8'h3C, 1, 8'h00, 1, 0, 0);

    // WIDTH=1: full-adder truth table.
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = v[2:0];
      tot = {1'b0, vv[2]} + {1'b0, vv[1]} + {1'b0, vv[0]};
      @(negedge clk);
      s1_a = vv[2]; s1_b = vv[1]; s1_cin = vv[0]; s1_op = 0; s1_start = 1'b1;
      @(posedge clk); #1;
      s1_start = 1'b0;
      chk($sformatf("w1 busy %0d", v), s1_busy, 1);
      @(posedge clk); #1;
      chk($sformatf("w1 done %0d", v), s1_done, 1);
      chk($sformatf("w1 sum %0d", v), s1_sum, tot[0]);
      chk($sformatf("w1 cout %0d", v), s1_cout, tot[1]);
      chk($sformatf("w1 ovf %0d", v), s1_ovf, vv[0] ^ tot[1]);
      @(posedge clk); #1;
      chk($sformatf("w1 done_end %0d", v), s1_done, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
